os_block_framer: RTL and testbench
==================================

Name: os_block_framer

Overview:
- Sits directly downstream of the QPSK transmitter (PRBS9 I/Q plus mapper) and upstream of the FFT in the frequency-domain equalizer path.
- Accepts a stream of 16-bit signed I/Q symbols under valid/ready handshake.
- Assembles overlap-save frames of NFFT samples: each frame is the last OVERLAP samples of the previous frame followed by HOP = NFFT-OVERLAP new samples.
- Emits each frame serially to the FFT with start/last markers.

Parameters:
- DW, 16, sample width per rail, signed two's complement.
- NFFT, 32, frame length; must be a power of 2, at least 4.
- OVERLAP, 16, samples reused from the previous frame; 1 ≤ OVERLAP < NFFT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  framer accepts a sample this cycle.
- in_I  in  DW  signed I sample.
- in_Q  in  DW  signed Q sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  FFT accepts the output sample.
- out_I  out  DW  signed I sample.
- out_Q  out  DW  signed Q sample.
- out_start  out  1  high on sample 0 of a frame.
- out_last  out  1  high on sample NFFT-1 of a frame.
- frame_cnt  out  16  number of frames fully emitted; wraps 0xFFFF→0.

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous, active-high.
- While reset is high:
  - All ring entries = 0; wr_ptr = 0; hop_cnt = 0; rd_cnt = 0; frame_cnt = 0.
  - in_ready = 0, out_valid = 0, out_start = 0, out_last = 0, out_I = out_Q = 0.
  - State = COLLECT.
- Storage: ring of NFFT entries of {I,Q}; write pointer wr_ptr runs modulo NFFT. Samples pass through bit-exact, with no scaling or sign change.
- COLLECT state:
  - in_ready = 1 from the first clock after reset deassertion; out_valid = 0.
  - A sample is accepted on a rising edge when in_valid && in_ready. It is written to ring[wr_ptr]; wr_ptr increments mod NFFT; hop_cnt increments.
  - in_valid = 0 stalls COLLECT indefinitely, with no state change.
  - On the edge accepting the HOP-th sample: hop_cnt → 0; state → EMIT; in_ready = 0 the following cycle.
- EMIT state:
  - Outputs NFFT samples, oldest first: ring[wr_ptr], ring[wr_ptr+1], …, ring[wr_ptr+NFFT-1], all indices mod NFFT.
  - out_valid rises exactly 1 clock after the accepting edge of the HOP-th input, presenting the first sample with out_start = 1.
  - Each out_valid && out_ready edge advances to the next sample, so back-to-back output at 1 sample/clk is possible.
  - While out_valid && !out_ready, out_I, out_Q, out_start and out_last hold stable.
  - out_last = 1 only on the NFFT-th sample.
  - On the handshake of the last sample: frame_cnt increments; out_valid = 0 the next cycle; state → COLLECT with in_ready = 1 the next cycle.
  - in_ready = 0 throughout EMIT. Input is never dropped and there is no overflow path.
- First frame after reset: OVERLAP zeros followed by the first HOP inputs, because the ring was cleared.
- Throughput: HOP inputs per (HOP + NFFT) cycles minimum, assuming upstream is always valid and the FFT is always ready.
- reset asserted mid-COLLECT or mid-EMIT: immediate abort; the partial frame is discarded; the ring is cleared; frame_cnt = 0.
- NFFT = power of 2 lets the ring index wrap by natural overflow of a log2(NFFT)-bit counter.

Decomposition:
- Shared package (eq_pkg) holds:
  - the DW default;
  - NFFT/OVERLAP defaults and derived HOP and AW = log2(NFFT);
  - FSM state encoding: COLLECT = 1'b0, EMIT = 1'b1.
- One natural sub-module, os_ring_buf: an NFFT x 2·DW register array with async clear, one write port, and one combinational read port.
- The FSM, counters and output registers stay in os_block_framer.

Test Plan (NFFT=8, OVERLAP=4, inputs I = n, Q = -n for n = 1,2,3,…):
- Reset release, in_valid=1, out_ready=1 → in_ready high 4 cycles; frame 0 out_I = 0,0,0,0,1,2,3,4 with out_Q mirrored; out_start on the 1st sample, out_last on the 8th; frame_cnt = 1.
- Continue streaming → frame 1 out_I = 1,2,3,4,5,6,7,8; frame 2 = 5,6,7,8,9,10,11,12; frame_cnt = 3; in_ready never high while out_valid is high.
- out_ready = 0 for 5 cycles at sample 3 of frame 1 → out_I holds 3 with out_valid high; the sequence resumes unchanged after the stall.
- in_valid toggling 1,0,1,0 → only accepted samples enter; frame contents are identical to the continuous case; out_valid first rises 1 clk after the 4th accept.
- Asynchronous reset pulse mid-EMIT of frame 1 → outputs zero immediately, frame_cnt = 0; the next frame is 0,0,0,0 followed by the first 4 new inputs.
- Signed extremes in_I = -32768, in_Q = 32767 → reproduced bit-exact at the output in the expected frame positions.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared parameters and FSM encoding for the overlap-save framer
// that sits between the QPSK transmitter and the FFT.
package eq_pkg;
  localparam int DW_DEF      = 16;
  localparam int NFFT_DEF    = 32;
  localparam int OVERLAP_DEF = 16;
  localparam int HOP_DEF     = NFFT_DEF - OVERLAP_DEF;
  localparam int AW_DEF      = $clog2(NFFT_DEF);

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } fr_state_e;
endpackage

// File: rtl/os_ring_buf.sv
// Frame ring: DEPTH x W register array with async clear, one write port
// and one combinational read port. DEPTH must be a power of two.
module os_ring_buf
  import eq_pkg::*;
#(
  parameter int W     = 2 * DW_DEF,
  parameter int DEPTH = NFFT_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/os_block_framer.sv
// Overlap-save framer: collects HOP new I/Q samples into the ring, then
// replays the whole NFFT-sample window oldest-first with start/last marks.
module os_block_framer
  import eq_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int NFFT    = NFFT_DEF,
  parameter int OVERLAP = OVERLAP_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_I,
  input  logic [DW-1:0] in_Q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_I,
  output logic [DW-1:0] out_Q,
  output logic          out_start,
  output logic          out_last,
  output logic [15:0]   frame_cnt
);

  localparam int HOP = NFFT - OVERLAP;
  localparam int AW  = $clog2(NFFT);

  fr_state_e     state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] hop_cnt_q, hop_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          out_start_q, out_start_d;
  logic          out_last_q, out_last_d;
  logic [DW-1:0] out_i_q, out_i_d;
  logic [DW-1:0] out_q_q, out_q_d;

  logic          accept;
  logic [AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;

  assign accept = in_valid && in_ready_q;

  // Look one sample ahead so the output registers load the next window entry;
  // in COLLECT that is the oldest entry once the final hop sample is written.
  assign rd_addr = wr_ptr_q + ((state_q == COLLECT) ? AW'(1) : (rd_cnt_q + AW'(1)));

  os_ring_buf #(
    .W     (2 * DW),
    .DEPTH (NFFT),
    .AW    (AW)
  ) u_ring (
    .clk     (clk),
    .rst_i   (reset),
    .we_i    (accept),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_I, in_Q}),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    hop_cnt_d   = hop_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    frame_cnt_d = frame_cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_start_d = out_start_q;
    out_last_d  = out_last_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    case (state_q)
      COLLECT: begin
        in_ready_d = 1'b1;
        if (accept) begin
          wr_ptr_d  = wr_ptr_q + AW'(1);
          hop_cnt_d = hop_cnt_q + AW'(1);
          if (hop_cnt_q == AW'(HOP - 1)) begin
            hop_cnt_d   = '0;
            rd_cnt_d    = '0;
            state_d     = EMIT;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_start_d = 1'b1;
            out_last_d  = 1'b0;
            {out_i_d, out_q_d} = rd_data;
          end
        end
      end
      EMIT: begin
        in_ready_d = 1'b0;
        if (out_valid_q && out_ready) begin
          if (rd_cnt_q == AW'(NFFT - 1)) begin
            state_d     = COLLECT;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_start_d = 1'b0;
            out_last_d  = 1'b0;
            out_i_d     = '0;
            out_q_d     = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            rd_cnt_d    = rd_cnt_q + AW'(1);
            out_start_d = 1'b0;
            out_last_d  = (rd_cnt_q == AW'(NFFT - 2));
            {out_i_d, out_q_d} = rd_data;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT;
      wr_ptr_q    <= '0;
      hop_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      frame_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      hop_cnt_q   <= hop_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      out_last_q  <= out_last_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_start = out_start_q;
  assign out_last  = out_last_q;
  assign out_I     = out_i_q;
  assign out_Q     = out_q_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_os_block_framer.sv
// Scoreboard bench for os_block_framer at NFFT=8, OVERLAP=4 with I=n, Q=-n.
module tb_os_block_framer;
  localparam int DW      = 16;
  localparam int NFFT    = 8;
  localparam int OVERLAP = 4;
  localparam int HOP     = NFFT - OVERLAP;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_I = '0;
  logic [DW-1:0] in_Q = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_I;
  logic [DW-1:0] out_Q;
  logic          out_start;
  logic          out_last;
  logic [15:0]   frame_cnt;

  os_block_framer #(.DW(DW), .NFFT(NFFT), .OVERLAP(OVERLAP)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_I(in_I), .in_Q(in_Q),
    .out_valid(out_valid), .out_ready(out_ready), .out_I(out_I), .out_Q(out_Q),
    .out_start(out_start), .out_last(out_last), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
    logic        st;
    logic        la;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_frame [NFFT];
  logic [31:0] new_samp[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          acc_cnt = 0;
  int          out_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual=timeout required=event (t=%0t)", name, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NFFT; k++) last_frame[k] = '0;
    new_samp.delete();
    sb.delete();
    acc_cnt = 0;
  endtask

  // Overlap-save window: tail OVERLAP of previous frame, then HOP fresh samples.
  task automatic model_accept(input logic [15:0] i, input logic [15:0] q);
    logic [31:0] fr [NFFT];
    new_samp.push_back({i, q});
    acc_cnt++;
    if (new_samp.size() == HOP) begin
      for (int k = 0; k < OVERLAP; k++) fr[k] = last_frame[HOP + k];
      for (int k = 0; k < HOP; k++) fr[OVERLAP + k] = new_samp[k];
      for (int k = 0; k < NFFT; k++)
        sb.push_back('{i: fr[k][31:16], q: fr[k][15:0], st: (k == 0), la: (k == NFFT - 1)});
      for (int k = 0; k < NFFT; k++) last_frame[k] = fr[k];
      new_samp.delete();
    end
  endtask

  task automatic push_sample(input logic [15:0] i, input logic [15:0] q);
    bit ok = 0;
    in_I = i;
    in_Q = q;
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (in_ready) begin
        if (acc_cnt % HOP == HOP - 1) chk("ov_before_hop", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_accept(i, q);
        if (acc_cnt % HOP == 0) begin
          chk("ov_latency", {31'd0, out_valid}, 32'd1);
          chk("start_first", {31'd0, out_start}, 32'd1);
          chk("rdy_drop", {31'd0, in_ready}, 32'd0);
        end
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      in_valid = 1'b0;
      fail_now("accept_timeout");
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid) begin
      chk("in_ready_excl", {31'd0, in_ready}, 32'd0);
      if (out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: actual I=%0h required=none", out_I);
        end else begin
          e = sb.pop_front();
          $display("out #%0d I=%0h Q=%0h start=%0b last=%0b", out_cnt, out_I, out_Q, out_start, out_last);
          out_cnt++;
          chk("out_I", {16'd0, out_I}, {16'd0, e.i});
          chk("out_Q", {16'd0, out_Q}, {16'd0, e.q});
          chk("out_start", {31'd0, out_start}, {31'd0, e.st});
          chk("out_last", {31'd0, out_last}, {31'd0, e.la});
        end
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_start"}, {31'd0, out_start}, 32'd0);
    chk({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    chk({tag, "_out_I"}, {16'd0, out_I}, 32'd0);
    chk({tag, "_out_Q"}, {16'd0, out_Q}, 32'd0);
    chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
  endtask

  initial begin
    model_reset();
    #12;
    chk_idle_outputs("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Continuous stream, three frames, with a 5-cycle FFT stall on frame 1.
    for (int n = 1; n <= 12; n++) begin
      push_sample(16'(n), 16'(-n));
      if (n == 8) begin
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("stall_entry_I", {16'd0, out_I}, 32'd3);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("stall_hold_I", {16'd0, out_I}, 32'd3);
          chk("stall_hold_Q", {16'd0, out_Q}, {16'd0, 16'hFFFD});
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    end
    wait_idle();
    chk("frame_cnt_3", {16'd0, frame_cnt}, 32'd3);

    // Fresh start, in_valid toggling, then async reset mid-EMIT of frame 1.
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int n = 1; n <= 8; n++) begin
      push_sample(16'(n), 16'(-n));
      if (n < 8) begin
        @(posedge clk);
        #1;
      end
    end
    chk("frame_cnt_pre", {16'd0, frame_cnt}, 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_idle_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Post-reset frame plus signed extremes on the third input.
    for (int n = 9; n <= 16; n++) begin
      if (n == 11) push_sample(16'h8000, 16'h7FFF);
      else push_sample(16'(n), 16'(-n));
    end
    wait_idle();
    chk("frame_cnt_2", {16'd0, frame_cnt}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
